// File: rtl/comb_delay_ctrl.sv
// Sequencing controller for the programmable-delay comb filter: accepts delay-line
// reconfigurations, flushes and zero-primes the comb, then un-gates live samples.
module comb_delay_ctrl #(
    parameter int DIN_WIDTH     = 8,
    parameter int DELAY_LINE    = 16,
    parameter int FLUSH_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 cfg_len,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic                        cfg_err,
    input  logic signed [DIN_WIDTH-1:0] s_din,
    input  logic                        s_din_valid,
    output logic signed [DIN_WIDTH-1:0] comb_din,
    output logic                        comb_din_valid,
    output logic                        comb_rst,
    output logic [31:0]                 delay_line,
    input  logic                        comb_dout_valid,
    output logic                        m_dout_valid,
    output logic                        running,
    output logic [15:0]                 drop_cnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FLUSH  = 3'd1;
    localparam logic [2:0] PRIME  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;

    localparam logic [31:0] MAX_LEN     = 32'(DELAY_LINE - 1);
    localparam logic [31:0] FLUSH_LOAD  = 32'(FLUSH_CYCLES - 1);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [31:0] cnt;
    logic [31:0] next_cnt;
    logic        accept;
    logic        len_ok;
    logic        start;

    assign cfg_ready    = rst && ((state == IDLE) || (state == RUN));
    assign accept       = cfg_valid && cfg_ready;
    assign len_ok       = (cfg_len != 32'd0) && (cfg_len <= MAX_LEN);
    assign start        = accept && len_ok;
    assign running      = (state == RUN);
    assign m_dout_valid = comb_dout_valid && (state == RUN);

    // One down-counter serves FLUSH, PRIME and SETTLE; PRIME loads delay_line so
    // it writes delay_line+1 zeros, one per comb memory slot.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    next_state = FLUSH;
                    next_cnt   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (cnt == 32'd0) begin
                    next_state = PRIME;
                    next_cnt   = delay_line;
                end else begin
                    next_cnt = cnt - 32'd1;
                end
            end
            PRIME: begin
                if (cnt == 32'd0) begin
                    next_state = SETTLE;
                    next_cnt   = SETTLE_LOAD;
                end else begin
                    next_cnt = cnt - 32'd1;
                end
            end
            SETTLE: begin
                if (cnt == 32'd0) begin
                    next_state = RUN;
                end else begin
                    next_cnt = cnt - 32'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            delay_line <= MAX_LEN;
            cfg_err    <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            cfg_err <= accept && !len_ok;
            if (start) begin
                delay_line <= cfg_len;
            end
        end
    end

    // Comb-side controls follow the upcoming state so they line up with it; RUN
    // is a plain registered passthrough, so the accept-cycle sample still lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            comb_rst       <= 1'b1;
            comb_din       <= '0;
            comb_din_valid <= 1'b0;
        end else begin
            comb_rst <= (next_state == IDLE) || (next_state == FLUSH);
            if (state == RUN) begin
                comb_din       <= s_din;
                comb_din_valid <= s_din_valid;
            end else begin
                comb_din       <= '0;
                comb_din_valid <= (next_state == PRIME);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= 16'd0;
        end else if (start) begin
            drop_cnt <= 16'd0;
        end else if (s_din_valid && (state != RUN) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_comb_delay_ctrl.sv
// Directed bench for comb_delay_ctrl, with a small valid-only model of the
// 3-stage comb pipeline feeding comb_dout_valid.
module tb_comb_delay_ctrl;

    localparam int DW = 8;
    localparam int DL = 16;
    localparam int FC = 2;
    localparam int SC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        cfg_len;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_err;
    logic signed [DW-1:0] s_din;
    logic               s_din_valid;
    logic signed [DW-1:0] comb_din;
    logic               comb_din_valid;
    logic               comb_rst;
    logic [31:0]        delay_line;
    logic               comb_dout_valid;
    logic               m_dout_valid;
    logic               running;
    logic [15:0]        drop_cnt;

    logic [2:0]         vpipe = 3'b000;

    int checks    = 0;
    int failures  = 0;
    int gate_viol = 0;
    logic in_run  = 1'b0;

    typedef struct {
        logic [31:0] len;
        logic        exp_err;
        logic [31:0] exp_dl;
    } cfg_vec_t;

    cfg_vec_t vecs [9];

    comb_delay_ctrl #(
        .DIN_WIDTH(DW),
        .DELAY_LINE(DL),
        .FLUSH_CYCLES(FC),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_len(cfg_len),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_err(cfg_err),
        .s_din(s_din),
        .s_din_valid(s_din_valid),
        .comb_din(comb_din),
        .comb_din_valid(comb_din_valid),
        .comb_rst(comb_rst),
        .delay_line(delay_line),
        .comb_dout_valid(comb_dout_valid),
        .m_dout_valid(m_dout_valid),
        .running(running),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (comb_rst) vpipe <= 3'b000;
        else          vpipe <= {vpipe[1:0], comb_din_valid};
    end
    assign comb_dout_valid = vpipe[2];

    always @(negedge clk) begin
        if (m_dout_valid !== (comb_dout_valid && running)) gate_viol++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] len, input logic cv,
                                 input logic [7:0] din, input logic dv);
        cfg_len     = len;
        cfg_valid   = cv;
        s_din       = din;
        s_din_valid = dv;
    endtask

    // Starts in the first FLUSH cycle, ends in the first RUN cycle.
    task automatic runSequence(input int len);
        for (int i = 0; i < FC; i++) begin
            checkOutput("flush_comb_rst", 32'(comb_rst), 32'd1);
            checkOutput("flush_running", 32'(running), 32'd0);
            step();
        end
        for (int i = 0; i < len + 1; i++) begin
            checkOutput("prime_comb_rst", 32'(comb_rst), 32'd0);
            checkOutput("prime_valid", 32'(comb_din_valid), 32'd1);
            checkOutput("prime_din", {24'd0, comb_din}, 32'd0);
            step();
        end
        for (int i = 0; i < SC; i++) begin
            checkOutput("settle_valid", 32'(comb_din_valid), 32'd0);
            checkOutput("settle_running", 32'(running), 32'd0);
            checkOutput("settle_comb_rst", 32'(comb_rst), 32'd0);
            step();
        end
        checkOutput("run_running", 32'(running), 32'd1);
        checkOutput("run_cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int bad_lens [2];

        vecs[0] = '{32'd0,         1'b1, 32'd15};
        vecs[1] = '{32'd16,        1'b1, 32'd15};
        vecs[2] = '{32'd7,         1'b0, 32'd7};
        vecs[3] = '{32'd0,         1'b1, 32'd7};
        vecs[4] = '{32'd16,        1'b1, 32'd7};
        vecs[5] = '{32'hFFFF_FFFF, 1'b1, 32'd7};
        vecs[6] = '{32'd1,         1'b0, 32'd1};
        vecs[7] = '{32'd15,        1'b0, 32'd15};
        vecs[8] = '{32'd3,         1'b0, 32'd3};

        rst = 1'b0;
        applyStimulus(32'd0, 1'b0, 8'd0, 1'b0);
        #12;
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("rst_comb_rst", 32'(comb_rst), 32'd1);
        checkOutput("rst_delay_line", delay_line, 32'd15);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("rst_din_valid", 32'(comb_din_valid), 32'd0);
        checkOutput("rst_m_dout", 32'(m_dout_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        $display("[TB] configuration table");
        for (int i = 0; i < 9; i++) begin
            checkOutput("cfg_ready_pre", 32'(cfg_ready), 32'd1);
            applyStimulus(vecs[i].len, 1'b1, 8'd0, 1'b0);
            step();
            cfg_valid = 1'b0;
            checkOutput("cfg_err", 32'(cfg_err), 32'(vecs[i].exp_err));
            checkOutput("delay_line", delay_line, vecs[i].exp_dl);
            if (vecs[i].exp_err) begin
                checkOutput("err_running", 32'(running), 32'(in_run));
                checkOutput("err_comb_rst", 32'(comb_rst), 32'(!in_run));
                step();
                checkOutput("err_pulse", 32'(cfg_err), 32'd0);
                checkOutput("err_running2", 32'(running), 32'(in_run));
            end else begin
                runSequence(int'(vecs[i].len));
                in_run = 1'b1;
            end
        end

        $display("[TB] passthrough latency");
        applyStimulus(32'd0, 1'b0, 8'd0, 1'b0);
        repeat (5) step();
        applyStimulus(32'd0, 1'b0, 8'd5, 1'b1);
        step();
        s_din_valid = 1'b0;
        checkOutput("lat_din", {24'd0, comb_din}, 32'd5);
        checkOutput("lat_din_valid", 32'(comb_din_valid), 32'd1);
        checkOutput("lat_m_dout_1", 32'(m_dout_valid), 32'd0);
        step();
        checkOutput("lat_m_dout_2", 32'(m_dout_valid), 32'd0);
        step();
        checkOutput("lat_m_dout_3", 32'(m_dout_valid), 32'd0);
        step();
        checkOutput("lat_m_dout_4", 32'(m_dout_valid), 32'd1);
        step();
        checkOutput("lat_m_dout_5", 32'(m_dout_valid), 32'd0);

        $display("[TB] streaming reconfiguration");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(32'd0, 1'b0, 8'(i), 1'b1);
            step();
            checkOutput("ramp_din", {24'd0, comb_din}, 32'(i));
            checkOutput("ramp_valid", 32'(comb_din_valid), 32'd1);
        end
        applyStimulus(32'd15, 1'b1, 8'd100, 1'b1);
        step();
        applyStimulus(32'd15, 1'b0, 8'd101, 1'b1);
        checkOutput("reconf_running0", 32'(running), 32'd0);
        checkOutput("reconf_m_dout", 32'(m_dout_valid), 32'd0);
        checkOutput("reconf_last_din", {24'd0, comb_din}, 32'd100);
        checkOutput("reconf_last_valid", 32'(comb_din_valid), 32'd1);
        checkOutput("reconf_drop_clr", 32'(drop_cnt), 32'd0);
        cyc = 0;
        while (running !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        checkOutput("reconf_running", 32'(running), 32'd1);
        checkOutput("reconf_cycles", 32'(cyc), 32'(FC + 15 + 1 + SC));
        checkOutput("reconf_drop", 32'(drop_cnt), 32'(FC + 15 + 1 + SC));
        checkOutput("reconf_dl", delay_line, 32'd15);
        step();
        checkOutput("reconf_pass_din", {24'd0, comb_din}, 32'd101);
        checkOutput("reconf_pass_valid", 32'(comb_din_valid), 32'd1);
        checkOutput("reconf_drop_hold", 32'(drop_cnt), 32'(FC + 15 + 1 + SC));

        $display("[TB] out-of-range while streaming");
        bad_lens[0] = 0;
        bad_lens[1] = 16;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'(bad_lens[i]), 1'b1, 8'(50 + 2 * i), 1'b1);
            step();
            applyStimulus(32'd0, 1'b0, 8'(51 + 2 * i), 1'b1);
            checkOutput("oor_err", 32'(cfg_err), 32'd1);
            checkOutput("oor_running", 32'(running), 32'd1);
            checkOutput("oor_din", {24'd0, comb_din}, 32'(50 + 2 * i));
            checkOutput("oor_valid", 32'(comb_din_valid), 32'd1);
            checkOutput("oor_dl", delay_line, 32'd15);
            step();
            checkOutput("oor_err_clr", 32'(cfg_err), 32'd0);
            checkOutput("oor_din2", {24'd0, comb_din}, 32'(51 + 2 * i));
            checkOutput("oor_valid2", 32'(comb_din_valid), 32'd1);
            checkOutput("oor_comb_rst", 32'(comb_rst), 32'd0);
        end

        $display("[TB] reset during PRIME");
        applyStimulus(32'd9, 1'b1, 8'd0, 1'b0);
        step();
        cfg_valid = 1'b0;
        repeat (4) step();
        checkOutput("prime_reached", 32'(comb_din_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_comb_rst", 32'(comb_rst), 32'd1);
        checkOutput("arst_running", 32'(running), 32'd0);
        checkOutput("arst_din_valid", 32'(comb_din_valid), 32'd0);
        checkOutput("arst_dl", delay_line, 32'd15);
        checkOutput("arst_cfg_ready", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) step();
        checkOutput("post_rst_running", 32'(running), 32'd0);
        checkOutput("post_rst_comb_rst", 32'(comb_rst), 32'd1);
        checkOutput("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("[TB] drop counter saturation");
        s_din_valid = 1'b1;
        repeat (65535) step();
        checkOutput("drop_full", 32'(drop_cnt), 32'hFFFF);
        repeat (4465) step();
        checkOutput("drop_sat", 32'(drop_cnt), 32'hFFFF);
        applyStimulus(32'd2, 1'b1, 8'd0, 1'b0);
        step();
        cfg_valid = 1'b0;
        checkOutput("drop_cleared", 32'(drop_cnt), 32'd0);
        checkOutput("sat_dl", delay_line, 32'd2);
        runSequence(2);

        step();
        checkOutput("m_dout_gate", 32'(gate_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comb_delay_ctrl.md
Name: comb_delay_ctrl

Overview:
Sequencing controller for the programmable-delay comb filter in the msdft correlator front end. It accepts delay-line reconfiguration requests over a valid/ready handshake and range-checks them. For each accepted request it flushes the comb, primes the delay memory with zeros and waits out the comb pipeline. Only then does it pass live samples through and un-gate the comb output valid, so downstream never sees stale-memory results after a length change.

Parameters:
DIN_WIDTH, 8, sample width; must match the comb DIN_WIDTH.
DELAY_LINE, 16, comb delay memory depth. Legal cfg_len range is 1..DELAY_LINE-1.
FLUSH_CYCLES, 2, cycles comb_rst is held per reconfiguration; must be >= 2 to cover the comb's internal delay_line register.
SETTLE_CYCLES, 4, post-prime wait; must be >= 4 (1 controller register plus 3 comb pipeline stages).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
cfg_len  in  32  requested delay_line value; comb depth is cfg_len+1
cfg_valid  in  1  config request valid
cfg_ready  out  1  high in IDLE and RUN only
cfg_err  out  1  one-cycle pulse when an accepted request is out of range
s_din  in  DIN_WIDTH  live sample (signed)
s_din_valid  in  1  live sample valid
comb_din  out  DIN_WIDTH  registered sample to comb din
comb_din_valid  out  1  registered valid to comb din_valid
comb_rst  out  1  active-high synchronous reset to comb
delay_line  out  32  registered length to comb delay_line
comb_dout_valid  in  1  comb dout_valid
m_dout_valid  out  1  comb_dout_valid AND (state==RUN), combinational
running  out  1  state==RUN
drop_cnt  out  16  samples discarded outside RUN; saturating

Behaviour:
- Reset (rst low, async) values:
  - state IDLE, delay_line=DELAY_LINE-1, comb_rst=1.
  - comb_din=0, comb_din_valid=0, cfg_err=0, drop_cnt=0, running=0, cfg_ready=0 while rst is low.
- States: IDLE, FLUSH, PRIME, SETTLE, RUN. Single down-counter cnt shared by FLUSH, PRIME and SETTLE.
- Handshake: a request is accepted when cfg_valid && cfg_ready at a rising edge.
  - In range (1 <= cfg_len <= DELAY_LINE-1): next cycle delay_line=cfg_len, drop_cnt=0, state=FLUSH, cnt=FLUSH_CYCLES-1.
  - Out of range (0 or >= DELAY_LINE): cfg_err=1 for exactly one cycle. State, delay_line and drop_cnt are unchanged.
- IDLE:
  - comb_rst=1, comb_din_valid=0.
  - Leaves only on an accepted in-range request.
- FLUSH:
  - comb_rst=1, comb_din_valid=0.
  - Lasts FLUSH_CYCLES cycles, then goes to PRIME with cnt=delay_line.
- PRIME:
  - comb_rst=0, comb_din=0, comb_din_valid=1 every cycle.
  - Lasts exactly delay_line+1 cycles, so every comb memory slot is written with zero.
  - Then goes to SETTLE with cnt=SETTLE_CYCLES-1.
- SETTLE:
  - comb_din_valid=0.
  - Lasts SETTLE_CYCLES cycles, then goes to RUN.
- RUN:
  - comb_din<=s_din and comb_din_valid<=s_din_valid (1-cycle registered passthrough).
  - End-to-end latency from s_din to comb dout is 4 cycles.
- Gating: m_dout_valid=0 in every state except RUN. Comb outputs generated from primed zeros are therefore never visible.
- drop_cnt: increments on each s_din_valid seen while state != RUN; saturates at 16'hFFFF.
- Reconfiguration while in RUN:
  - Accepted in-range request moves to FLUSH on the next edge; m_dout_valid drops that same cycle.
  - Samples in flight inside the comb are discarded.
  - A sample presented in the accept cycle is still registered to comb_din (comb_din_valid=1 on the next cycle) and is not counted as dropped.
- Out-of-range request in RUN: cfg_err pulse only; passthrough continues without a gap.
- cfg_valid outside IDLE/RUN: ignored (cfg_ready=0). The requester must hold the request until ready.
- rst asserted mid-sequence: immediate return to reset values. A new configuration is required after release.

Test Plan:
- Reset release, cfg_len=7 accepted -> comb_rst high 2 cycles; comb_din_valid=1 with comb_din=0 for 8 cycles; 4 idle cycles; running=1; m_dout_valid first asserts 4 cycles after the first live s_din_valid.
- In RUN, drive ramp 1,2,3,... with cfg_len=3 -> comb dout equals x[n]-x[n-4]=4 once the memory holds live data. The first 4 outputs are x[n]-0 (primed zeros), never garbage.
- cfg_len=0, then cfg_len=16 (DELAY_LINE=16) -> cfg_err one-cycle pulse each; delay_line and state unchanged; no comb_rst activity.
- Streaming continuously in RUN, request cfg_len=15 -> m_dout_valid low from the next cycle; full FLUSH/PRIME (16 cycles)/SETTLE sequence; drop_cnt equals the number of valid samples presented during the sequence.
- Hold s_din_valid=1 outside RUN for 70000 cycles -> drop_cnt saturates at 65535; the next accepted config clears it to 0.
- Assert rst during PRIME -> outputs return to reset values asynchronously; comb_rst=1, running=0; no m_dout_valid until a new config completes.
